// File: rtl/ins_fetch.sv
// Instruction fetch sequencer: fetches one word, offers it to the decoder,
// paces execution, then advances or redirects the PC.
module ins_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          EXEC_CYCLES = 4,
  parameter int          TIMEOUT     = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {FETCH, WAIT, ISSUE, EXEC, DONE} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
  localparam logic [3:0] EXEC_LAST = 4'(EXEC_CYCLES - 1);

  state_t      state, state_nx;
  logic [31:0] pc;
  logic [7:0]  wait_cnt;
  logic [3:0]  exec_cnt;
  logic        halt_pend;
  logic        redir_pend;
  logic [31:0] redir_pc;
  logic [31:0] redirect_al;
  logic [31:0] pc_nx;

  assign redirect_al = redirect_pc & 32'hFFFF_FFFC;

  // The current cycle's redirect is the newest sample, so it beats a stored one.
  always_comb begin
    pc_nx = pc + 32'd4;
    if (redirect_valid)
      pc_nx = redirect_al;
    else if (redir_pend)
      pc_nx = redir_pc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= FETCH;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      FETCH: state_nx = WAIT;
      WAIT: begin
        if (mem_rvalid)
          state_nx = (mem_rdata == 32'h0000_0000) ? DONE : ISSUE;
        else if (wait_cnt == WAIT_LAST)
          state_nx = DONE;
      end
      ISSUE: if (instr_ready) state_nx = EXEC;
      EXEC: begin
        if (exec_cnt == EXEC_LAST)
          state_nx = (halt || halt_pend) ? DONE : FETCH;
      end
      DONE:    state_nx = DONE;
      default: state_nx = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= RESET_PC;
      instr      <= 32'h0;
      instr_pc   <= 32'h0;
      wait_cnt   <= 8'h0;
      exec_cnt   <= 4'h0;
      halt_pend  <= 1'b0;
      redir_pend <= 1'b0;
      redir_pc   <= 32'h0;
      err        <= 1'b0;
    end else begin
      if (halt)
        halt_pend <= 1'b1;
      case (state)
        WAIT: begin
          if (mem_rvalid) begin
            instr    <= mem_rdata;
            instr_pc <= pc;
            wait_cnt <= 8'h0;
          end else if (wait_cnt == WAIT_LAST) begin
            err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        EXEC: begin
          if (redirect_valid) begin
            redir_pend <= 1'b1;
            redir_pc   <= redirect_al;
          end
          if (exec_cnt == EXEC_LAST) begin
            exec_cnt   <= 4'h0;
            redir_pend <= 1'b0;
            pc         <= pc_nx;
          end else begin
            exec_cnt <= exec_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req     = (state == FETCH);
  assign mem_addr    = pc;
  assign instr_valid = (state == ISSUE);
  assign done        = (state == DONE);

endmodule
